// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Hazard detection and operand-forwarding controller for the EX-stage
// operand muxes. Tracks in-flight register writes in a 3-entry scoreboard
// (EX, MEM, WB), produces registered A/B forward selects, and generates the
// load-use stall / bubble controls for the IF/ID and ID/EX registers.
//
// Build option: define FWD_EN to enable operand forwarding. With FWD_EN
// undefined (the default) the selects stay at register-file and every
// dependence on the EX or MEM entry stalls until the producer reaches WB.
module hazard_fwd_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } sb_entry_t;

    sb_entry_t sb_ex, sb_mem, sb_wb;

    logic     m_ex_a, m_ex_b, m_mem_a, m_mem_b, m_wb_a, m_wb_b;
    logic     hazard;
    fwd_sel_t sel_a_nxt, sel_b_nxt;
    logic     unused_bits;

    function automatic logic src_match(input sb_entry_t e,
                                       input logic [REG_ADDR_W-1:0] s,
                                       input logic use_s);
        return e.v && (e.rd == s) && (s != '0) && use_s;
    endfunction

    // Source matches against each scoreboard entry.
    always_comb begin
        m_ex_a  = src_match(sb_ex,  id_rs1, id_use_rs1);
        m_ex_b  = src_match(sb_ex,  id_rs2, id_use_rs2);
        m_mem_a = src_match(sb_mem, id_rs1, id_use_rs1);
        m_mem_b = src_match(sb_mem, id_rs2, id_use_rs2);
        m_wb_a  = src_match(sb_wb,  id_rs1, id_use_rs1);
        m_wb_b  = src_match(sb_wb,  id_rs2, id_use_rs2);
    end

    // Hazard detection and next forward selects; newest producer wins.
    // A WB match reads the register file, which is written in the first
    // half-cycle, so it maps to SEL_RF.
    always_comb begin
        hazard    = 1'b0;
        sel_a_nxt = SEL_RF;
        sel_b_nxt = SEL_RF;
`ifdef FWD_EN
        hazard = (m_ex_a || m_ex_b) && sb_ex.ld;
        if (m_ex_a && !sb_ex.ld) sel_a_nxt = SEL_EXMEM;
        else if (m_mem_a)        sel_a_nxt = SEL_MEMWB;
        else if (m_wb_a)         sel_a_nxt = SEL_RF;
        if (m_ex_b && !sb_ex.ld) sel_b_nxt = SEL_EXMEM;
        else if (m_mem_b)        sel_b_nxt = SEL_MEMWB;
        else if (m_wb_b)         sel_b_nxt = SEL_RF;
`else
        hazard = m_ex_a || m_ex_b || m_mem_a || m_mem_b;
        if (m_wb_a) sel_a_nxt = SEL_RF;
        if (m_wb_b) sel_b_nxt = SEL_RF;
`endif
    end

    // Pipeline controls; flush kills the ID instruction and overrides a stall.
    always_comb begin
        stall_id  = id_valid && hazard && !flush;
        bubble_ex = stall_id || flush;
    end

    // Scoreboard shift, registered selects and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_ex     <= '0;
            sb_mem    <= '0;
            sb_wb     <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            stall_cnt <= '0;
        end else begin
            sb_wb    <= sb_mem;
            sb_mem   <= sb_ex;
            sb_ex.v  <= id_valid && id_we && (id_rd != '0) && !stall_id && !flush;
            sb_ex.rd <= id_rd;
            sb_ex.ld <= id_is_load;
            if (stall_id || bubble_ex || flush || !id_valid) begin
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end else begin
                fwd_a_sel <= sel_a_nxt;
                fwd_b_sel <= sel_b_nxt;
            end
            if (stall_id && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Load flags of the older entries are tracked but not consulted.
    assign unused_bits = ^{sb_ex.ld, sb_mem.ld, sb_wb.ld};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit; expectations follow FWD_EN.
module tb_hazard_fwd_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_we, id_is_load, flush;
    logic          stall_id, bubble_ex;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    hazard_fwd_unit #(.REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .flush(flush), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_comb(input string tag, input logic s, input logic b);
        chk({tag, "_stall"},  16'(stall_id),  16'(s));
        chk({tag, "_bubble"}, 16'(bubble_ex), 16'(b));
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "_sel_a"}, 16'(fwd_a_sel), 16'(a));
        chk({tag, "_sel_b"}, 16'(fwd_b_sel), 16'(b));
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cnt"}, 16'(stall_cnt), 16'(exp_cnt));
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic we, input logic ld);
        id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_we = we; id_is_load = ld; flush = 1'b0;
    endtask

    task automatic nop();
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rd = '0; id_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        int per, iters;
        nop();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk_comb("rst", 1'b0, 1'b0);
        chk_sel("rst", 2'b00, 2'b00);
        chk_cnt("rst");

        // 1: ADD r3<-r1,r2 ; SUB r4<-r3,r5
        instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0); #1;
        chk_comb("t1_add", 1'b0, 1'b0);
        tick();
        instr(5'd3, 5'd5, 1, 1, 5'd4, 1, 0); #1;
`ifdef FWD_EN
        chk_comb("t1_sub", 1'b0, 1'b0);
        tick();
        chk_sel("t1_ex", 2'b01, 2'b00);
`else
        chk_comb("t1_s1", 1'b1, 1'b1);
        tick();
        chk_sel("t1_s1", 2'b00, 2'b00);
        chk_comb("t1_s2", 1'b1, 1'b1);
        tick();
        chk_sel("t1_s2", 2'b00, 2'b00);
        chk_comb("t1_go", 1'b0, 1'b0);
        tick();
        chk_sel("t1_ex", 2'b00, 2'b00);
        exp_cnt += 2;
`endif
        chk_cnt("t1");
        drain();

        // 2a: ADD r3 ; NOP ; SUB r4<-r5,r3
        instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        nop(); tick();
        instr(5'd5, 5'd3, 1, 1, 5'd4, 1, 0); #1;
`ifdef FWD_EN
        chk_comb("t2a", 1'b0, 1'b0);
        tick();
        chk_sel("t2a", 2'b00, 2'b10);
`else
        chk_comb("t2a_s1", 1'b1, 1'b1);
        tick();
        chk_comb("t2a_go", 1'b0, 1'b0);
        tick();
        chk_sel("t2a", 2'b00, 2'b00);
        exp_cnt += 1;
`endif
        chk_cnt("t2a");
        drain();

        // 2b: ADD r3 ; NOP ; NOP ; SUB r4<-r3,r5
        instr(5'd1, 5'd2, 1, 1, 5'd3, 1, 0); tick();
        nop(); tick();
        tick();
        instr(5'd3, 5'd5, 1, 1, 5'd4, 1, 0); #1;
        chk_comb("t2b", 1'b0, 1'b0);
        tick();
        chk_sel("t2b", 2'b00, 2'b00);
        drain();

        // 3: LW r6 ; ADD r7<-r6,r6
        instr(5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();
        instr(5'd6, 5'd6, 1, 1, 5'd7, 1, 0); #1;
        chk_comb("t3_s1", 1'b1, 1'b1);
        tick();
        chk_sel("t3_s1", 2'b00, 2'b00);
`ifdef FWD_EN
        chk_comb("t3_go", 1'b0, 1'b0);
        tick();
        chk_sel("t3_ex", 2'b10, 2'b10);
        exp_cnt += 1;
`else
        chk_comb("t3_s2", 1'b1, 1'b1);
        tick();
        chk_comb("t3_go", 1'b0, 1'b0);
        tick();
        chk_sel("t3_ex", 2'b00, 2'b00);
        exp_cnt += 2;
`endif
        chk_cnt("t3");
        drain();

        // 4a: ADDI r0 ; ADD r1<-r0,r0
        instr(5'd1, 5'd0, 1, 0, 5'd0, 1, 0); tick();
        instr(5'd0, 5'd0, 1, 1, 5'd1, 1, 0); #1;
        chk_comb("t4a", 1'b0, 1'b0);
        tick();
        chk_sel("t4a", 2'b00, 2'b00);
        // 4b: ADD r2 ; ADD r2 ; use r2
        instr(5'd8, 5'd9, 1, 1, 5'd2, 1, 0); #1;
        chk_comb("t4b_p1", 1'b0, 1'b0);
        tick();
        instr(5'd8, 5'd9, 1, 1, 5'd2, 1, 0); tick();
        instr(5'd2, 5'd10, 1, 1, 5'd11, 1, 0); #1;
`ifdef FWD_EN
        chk_comb("t4b", 1'b0, 1'b0);
        tick();
        chk_sel("t4b", 2'b01, 2'b00);
`else
        chk_comb("t4b_s1", 1'b1, 1'b1);
        tick();
        chk_comb("t4b_s2", 1'b1, 1'b1);
        tick();
        chk_comb("t4b_go", 1'b0, 1'b0);
        tick();
        chk_sel("t4b", 2'b00, 2'b00);
        exp_cnt += 2;
`endif
        chk_cnt("t4b");
        drain();

        // 5a: LW r6 ; ADD r7<-r6 flushed
        instr(5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();
        instr(5'd6, 5'd0, 1, 0, 5'd7, 1, 0);
        flush = 1'b1; #1;
        chk_comb("t5_flush", 1'b0, 1'b1);
        tick();
        chk_sel("t5_flush", 2'b00, 2'b00);
        chk_cnt("t5_flush");
        // killed ADD r7 must not be in the scoreboard
        instr(5'd7, 5'd0, 1, 0, 5'd8, 1, 0); #1;
        chk_comb("t5_killed", 1'b0, 1'b0);
        tick();
        chk_sel("t5_killed", 2'b00, 2'b00);
        drain();

        // 5b: reset during a load-use stall
        instr(5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();
        instr(5'd6, 5'd6, 1, 1, 5'd7, 1, 0); #1;
        chk_comb("t5r_pre", 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        exp_cnt = 0;
        chk_comb("t5r_post", 1'b0, 1'b0);
        chk_sel("t5r_post", 2'b00, 2'b00);
        chk_cnt("t5r_post");
        tick();
        chk_sel("t5r_next", 2'b00, 2'b00);
        drain();

        // 6: saturation of the stall counter
`ifdef FWD_EN
        per = 1; iters = 20;
`else
        per = 2; iters = 10;
`endif
        for (int i = 0; i < iters; i++) begin
            instr(5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();
            instr(5'd6, 5'd6, 1, 1, 5'd7, 0, 0);
            repeat (per + 1) tick();
            exp_cnt = (exp_cnt + per > 15) ? 15 : exp_cnt + per;
            chk_cnt($sformatf("t6_it%0d", i));
        end
        chk("t6_sat", 16'(stall_cnt), 16'd15);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
